// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch control unit.
package stopwatch_pkg;

    // FSM state encodings, also driven out on o_state for debug LEDs.
    localparam logic [1:0] ST_STOP  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_CLEAR = 2'b10;

    typedef enum logic [1:0] {
        STATE_STOP  = ST_STOP,
        STATE_RUN   = ST_RUN,
        STATE_CLEAR = ST_CLEAR,
        STATE_BAD   = 2'b11
    } state_t;

    // Display select values understood by fnd_control.
    localparam logic MODE_MSEC_SEC = 1'b0;
    localparam logic MODE_MIN_HOUR = 1'b1;

    // Button positions inside the packed button vector.
    localparam int NUM_BTNS  = 4;
    localparam int BTN_RUN   = 0;
    localparam int BTN_CLEAR = 1;
    localparam int BTN_MODE  = 2;
    localparam int BTN_LAP   = 3;

    // Width of the clear-duration counter.
    localparam int CLR_CNT_W = 4;

    // Flip the display mode between its two legal values.
    function automatic logic toggle_mode(input logic mode);
        return (mode == MODE_MIN_HOUR) ? MODE_MSEC_SEC : MODE_MIN_HOUR;
    endfunction

endpackage

// File: rtl/stopwatch_cu_if.sv
// Button inputs and control outputs of the stopwatch control unit.
interface stopwatch_cu_if;
    logic       btn_run_stop;
    logic       btn_clear;
    logic       btn_mode;
    logic       btn_lap;
    logic       o_run;
    logic       o_clear;
    logic       o_sw_mode;
    logic       o_hold;
    logic [1:0] o_state;

    // Driver side: debouncers feed buttons, counter/display consume controls.
    modport master (
        output btn_run_stop, btn_clear, btn_mode, btn_lap,
        input  o_run, o_clear, o_sw_mode, o_hold, o_state
    );

    // Control unit side.
    modport slave (
        input  btn_run_stop, btn_clear, btn_mode, btn_lap,
        output o_run, o_clear, o_sw_mode, o_hold, o_state
    );
endinterface

// File: rtl/btn_edge.sv
// Rising-edge detector: turns a debounced button level into a one-cycle press.
// The history flop resets high so a button held through reset is not a press.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    logic btn_d_reg;

    // Remember the previous sampled level.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_d_reg <= 1'b1;
        end else begin
            btn_d_reg <= btn;
        end
    end

    assign press = btn & ~btn_d_reg;
endmodule

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: STOP/RUN/CLEAR sequencer, display-mode select and
// lap-hold flag. All outputs come straight from flops, one clock after the
// button edge that caused them.
module stopwatch_cu
    import stopwatch_pkg::*;
#(
    parameter int CLEAR_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    stopwatch_cu_if.slave  sw
);
    // Terminal count of the clear pulse; the counter starts at 0 on entry.
    localparam logic [CLR_CNT_W-1:0] CLR_LAST = CLR_CNT_W'(CLEAR_CYCLES - 1);

    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_press;

    assign btn_level[BTN_RUN]   = sw.btn_run_stop;
    assign btn_level[BTN_CLEAR] = sw.btn_clear;
    assign btn_level[BTN_MODE]  = sw.btn_mode;
    assign btn_level[BTN_LAP]   = sw.btn_lap;

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            btn_edge u_btn_edge (
                .clk   (clk),
                .reset (reset),
                .btn   (btn_level[gi]),
                .press (btn_press[gi])
            );
        end
    endgenerate

    logic press_run;
    logic press_clear;
    logic press_mode;
    logic press_lap;

    assign press_run   = btn_press[BTN_RUN];
    assign press_clear = btn_press[BTN_CLEAR];
    assign press_mode  = btn_press[BTN_MODE];
    assign press_lap   = btn_press[BTN_LAP];

    state_t               state_reg,   state_next;
    logic [CLR_CNT_W-1:0] clr_cnt_reg, clr_cnt_next;
    logic                 mode_reg,    mode_next;
    logic                 hold_reg,    hold_next;
    logic                 run_reg,     run_next;
    logic                 clear_reg,   clear_next;

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= STATE_STOP;
            clr_cnt_reg <= '0;
            mode_reg    <= MODE_MSEC_SEC;
            hold_reg    <= 1'b0;
            run_reg     <= 1'b0;
            clear_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
            mode_reg    <= mode_next;
            hold_reg    <= hold_next;
            run_reg     <= run_next;
            clear_reg   <= clear_next;
        end
    end

    // Next-state, clear counter, mode and hold decisions.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        mode_next    = press_mode ? toggle_mode(mode_reg) : mode_reg;
        hold_next    = hold_reg;

        case (state_reg)
            STATE_STOP: begin
                // Run beats clear when both rise together; the clear is dropped.
                if (press_run) begin
                    state_next = STATE_RUN;
                end else if (press_clear) begin
                    state_next   = STATE_CLEAR;
                    clr_cnt_next = '0;
                    hold_next    = 1'b0;
                end
                if (press_lap) begin
                    hold_next = 1'b0;
                end
            end
            STATE_RUN: begin
                // Clear is ignored while running; hold survives RUN->STOP.
                if (press_run) begin
                    state_next = STATE_STOP;
                end
                if (press_lap) begin
                    hold_next = ~hold_reg;
                end
            end
            STATE_CLEAR: begin
                // Presses of run/clear here are simply not acted on.
                if (clr_cnt_reg == CLR_LAST) begin
                    state_next = STATE_STOP;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next   = STATE_STOP;
                clr_cnt_next = '0;
                mode_next    = MODE_MSEC_SEC;
                hold_next    = 1'b0;
            end
        endcase

        run_next   = (state_next == STATE_RUN);
        clear_next = (state_next == STATE_CLEAR);
    end

    assign sw.o_run     = run_reg;
    assign sw.o_clear   = clear_reg;
    assign sw.o_sw_mode = mode_reg;
    assign sw.o_hold    = hold_reg;
    assign sw.o_state   = state_reg;
endmodule

// File: tb/tb_stopwatch_cu.sv
// Testbench for stopwatch_cu: directed vector table, a clear-length sequence,
// and randomized button traffic against a behavioural model.
module tb_stopwatch_cu;
    localparam int CLEAR_CYCLES = 2;

    // Button bit positions in the 4-bit stimulus word.
    localparam logic [3:0] R = 4'b0001;
    localparam logic [3:0] C = 4'b0010;
    localparam logic [3:0] M = 4'b0100;
    localparam logic [3:0] L = 4'b1000;
    localparam logic [3:0] N = 4'b0000;

    logic clk = 1'b0;
    logic reset;

    stopwatch_cu_if sw();

    stopwatch_cu #(.CLEAR_CYCLES(CLEAR_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [3:0] btn;
        logic       run;
        logic       clr;
        logic       mode;
        logic       hold;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: 0=STOP, 1=RUN, 2=CLEAR; clear counts remaining cycles.
    int         m_state;
    int         m_left;
    logic       m_mode;
    logic       m_hold;
    logic [3:0] m_prev;

    function automatic void add(input logic r, input logic [3:0] b, input logic run,
                                input logic clr, input logic mode, input logic hold,
                                input logic [1:0] st);
        vec_t v;
        v.rst = r; v.btn = b; v.run = run; v.clr = clr;
        v.mode = mode; v.hold = hold; v.st = st;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic r, input logic [3:0] b);
        reset           = r;
        sw.btn_run_stop = b[0];
        sw.btn_clear    = b[1];
        sw.btn_mode     = b[2];
        sw.btn_lap      = b[3];
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic run, input logic clr,
                             input logic mode, input logic hold, input logic [1:0] st);
        check({tag, ".o_run"},     int'(sw.o_run),     int'(run));
        check({tag, ".o_clear"},   int'(sw.o_clear),   int'(clr));
        check({tag, ".o_sw_mode"}, int'(sw.o_sw_mode), int'(mode));
        check({tag, ".o_hold"},    int'(sw.o_hold),    int'(hold));
        check({tag, ".o_state"},   int'(sw.o_state),   int'(st));
    endtask

    task automatic model_step(input logic r, input logic [3:0] b);
        logic [3:0] p;
        if (r) begin
            m_state = 0; m_left = 0; m_mode = 1'b0; m_hold = 1'b0; m_prev = 4'hF;
            return;
        end
        p      = b & ~m_prev;
        m_prev = b;
        if (p[2]) m_mode = ~m_mode;
        if (m_state == 0) begin
            if (p[0]) m_state = 1;
            else if (p[1]) begin m_state = 2; m_left = CLEAR_CYCLES; m_hold = 1'b0; end
            if (p[3]) m_hold = 1'b0;
        end else if (m_state == 1) begin
            if (p[3]) m_hold = ~m_hold;
            if (p[0]) m_state = 0;
        end else begin
            m_left--;
            if (m_left == 0) m_state = 0;
        end
    endtask

    initial begin
        int         n;
        bit         done;
        logic [3:0] cur;
        logic       r;

        // 1: run button held through reset and afterwards produces nothing.
        add(1, R, 0,0,0,0, 2'b00);
        add(1, R, 0,0,0,0, 2'b00);
        for (int i = 0; i < 10; i++) add(0, R, 0,0,0,0, 2'b00);
        // 2: start on first high sample, held level ignored, second press stops.
        add(0, N, 0,0,0,0, 2'b00);
        add(0, R, 1,0,0,0, 2'b01);
        add(0, R, 1,0,0,0, 2'b01);
        add(0, R, 1,0,0,0, 2'b01);
        add(0, N, 1,0,0,0, 2'b01);
        add(0, R, 0,0,0,0, 2'b00);
        add(0, N, 0,0,0,0, 2'b00);
        // 3: clear lasts two cycles; a run press inside it is discarded.
        add(0, C, 0,1,0,0, 2'b10);
        add(0, R, 0,1,0,0, 2'b10);
        add(0, R, 0,0,0,0, 2'b00);
        add(0, N, 0,0,0,0, 2'b00);
        // 4: simultaneous run+clear from STOP -> RUN, no clear pulse.
        add(0, R|C, 1,0,0,0, 2'b01);
        add(0, N,   1,0,0,0, 2'b01);
        add(0, R,   0,0,0,0, 2'b00);
        add(0, N,   0,0,0,0, 2'b00);
        // 5: lap hold in RUN, clear ignored, hold survives stop, lap in STOP drops it.
        add(0, R, 1,0,0,0, 2'b01);
        add(0, N, 1,0,0,0, 2'b01);
        add(0, L, 1,0,0,1, 2'b01);
        add(0, N, 1,0,0,1, 2'b01);
        add(0, C, 1,0,0,1, 2'b01);
        add(0, N, 1,0,0,1, 2'b01);
        add(0, R, 0,0,0,1, 2'b00);
        add(0, N, 0,0,0,1, 2'b00);
        add(0, L, 0,0,0,0, 2'b00);
        add(0, N, 0,0,0,0, 2'b00);
        // 6: mode toggles in RUN, CLEAR and STOP; reset in CLEAR clears all.
        add(0, R, 1,0,0,0, 2'b01);
        add(0, M, 1,0,1,0, 2'b01);
        add(0, N, 1,0,1,0, 2'b01);
        add(0, R, 0,0,1,0, 2'b00);
        add(0, C, 0,1,1,0, 2'b10);
        add(0, M, 0,1,0,0, 2'b10);
        add(0, N, 0,0,0,0, 2'b00);
        add(0, M, 0,0,1,0, 2'b00);
        add(0, N, 0,0,1,0, 2'b00);
        add(0, C, 0,1,1,0, 2'b10);
        add(1, N, 0,0,0,0, 2'b00);
        add(0, N, 0,0,0,0, 2'b00);

        drive(1, R);
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].btn);
            @(posedge clk);
            #1;
            $display("vec %0d rst=%b btn=%b -> run=%b clr=%b mode=%b hold=%b st=%b",
                     i, vecs[i].rst, vecs[i].btn, sw.o_run, sw.o_clear,
                     sw.o_sw_mode, sw.o_hold, sw.o_state);
            check_all($sformatf("vec%0d", i), vecs[i].run, vecs[i].clr,
                      vecs[i].mode, vecs[i].hold, vecs[i].st);
        end

        // Clear pulse length, measured with a bounded wait.
        @(negedge clk);
        drive(0, C);
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) drive(0, N);
            if (sw.o_clear) n++;
            else done = 1'b1;
        end
        $display("clear_seq: o_clear high for %0d cycles", n);
        check("clear_len", n, CLEAR_CYCLES);
        check("clear_exit", int'(done), 1);
        check("clear_state", int'(sw.o_state), 0);

        // Randomized traffic against the model.
        @(negedge clk);
        drive(1, N);
        @(posedge clk);
        model_step(1, N);
        #1;
        cur = N;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            r   = ($urandom_range(0, 99) == 0);
            cur = cur ^ (4'($urandom) & 4'($urandom));
            drive(r, cur);
            @(posedge clk);
            model_step(r, cur);
            #1;
            $display("rnd %0d rst=%b btn=%b -> run=%b clr=%b mode=%b hold=%b st=%b",
                     i, r, cur, sw.o_run, sw.o_clear, sw.o_sw_mode, sw.o_hold, sw.o_state);
            check_all($sformatf("rnd%0d", i), m_state == 1, m_state == 2,
                      m_mode, m_hold, 2'(m_state));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
